jt89_stereo: RTL and testbench

//  Parametrised SN76489-family PSG: 3 tone channels + 1 noise channel, Game Gear stereo panning,

---
 rtl/jt89_stereo.sv | 261 ++++++++++++++++++++++++++
 tb/tb_jt89_stereo.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/jt89_stereo.sv
// jt89_stereo: SN76489-family PSG (3 tone + 1 noise) with Game Gear stereo panning,
// selectable LFSR flavour and a READY handshake that holds off CPU writes while busy.
module jt89_stereo #(
    parameter int          DIV       = 16,
    parameter int          NOISE_W   = 16,
    parameter logic [15:0] NOISE_TAP = 16'h0009,
    parameter int          WAIT_CYC  = 32,
    parameter bit          STEREO    = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clk_en,
    input  logic       wr_n,
    input  logic       gg_wr_n,
    input  logic [7:0] din,
    output logic       ready,
    output logic [9:0] left,
    output logic [9:0] right
);

    localparam int                 DW       = $clog2(DIV);
    localparam logic [DW-1:0]      DIV_LAST = DW'(DIV - 1);
    localparam logic [15:0]        WAIT_LD  = 16'(WAIT_CYC);
    localparam logic [NOISE_W-1:0] SEED     = {1'b1, {(NOISE_W-1){1'b0}}};
    localparam logic [NOISE_W-1:0] TAP      = NOISE_TAP[NOISE_W-1:0];

    function automatic logic [7:0] att_lut(input logic [3:0] v);
        case (v)
            4'd0:    att_lut = 8'd255;
            4'd1:    att_lut = 8'd203;
            4'd2:    att_lut = 8'd161;
            4'd3:    att_lut = 8'd128;
            4'd4:    att_lut = 8'd102;
            4'd5:    att_lut = 8'd81;
            4'd6:    att_lut = 8'd64;
            4'd7:    att_lut = 8'd51;
            4'd8:    att_lut = 8'd40;
            4'd9:    att_lut = 8'd32;
            4'd10:   att_lut = 8'd26;
            4'd11:   att_lut = 8'd20;
            4'd12:   att_lut = 8'd16;
            4'd13:   att_lut = 8'd13;
            4'd14:   att_lut = 8'd10;
            4'd15:   att_lut = 8'd0;
            default: att_lut = 8'd0;
        endcase
    endfunction

    logic                wr_q, wr_d, gg_q, gg_d;
    logic                ready_q, ready_d;
    logic [15:0]         wait_q, wait_d;
    logic [2:0]          regn_q, regn_d, ctrl3_q, ctrl3_d;
    logic [3:0]          vol_q [4];
    logic [3:0]          vol_d [4];
    logic [9:0]          tone_q [3];
    logic [9:0]          tone_d [3];
    logic [9:0]          cnt_q [3];
    logic [9:0]          cnt_d [3];
    logic [2:0]          tout_q, tout_d;
    logic [7:0]          pan_q, pan_d;
    logic [DW-1:0]       div_q, div_d;
    logic [5:0]          ndiv_q, ndiv_d, nlast_s;
    logic                nint_q, nint_d, nsrc_q, nsrc_d;
    logic [NOISE_W-1:0]  lfsr_q, lfsr_d;
    logic [9:0]          left_q, left_d, right_q, right_d;

    logic                wr_acc_s, gg_acc_s, cen_ch_s, reseed_s, nclk_s, fb_s;
    logic [3:0]          on_s;
    logic [7:0]          lvl_s [4];
    logic [9:0]          mix_l_s, mix_r_s;

    // A write is only taken on a strobe falling edge while READY is high.
    assign wr_acc_s = wr_q & ~wr_n & ready_q;
    assign gg_acc_s = (STEREO != 1'b0) & gg_q & ~gg_wr_n;
    assign cen_ch_s = clk_en & (div_q == DIV_LAST);
    assign nclk_s   = (ctrl3_q[1:0] == 2'b11) ? tout_q[2] : nint_q;
    assign fb_s     = ctrl3_q[2] ? ^(lfsr_q & TAP) : lfsr_q[0];
    assign on_s     = {lfsr_q[0], tout_q};

    // Next-state logic for the bus interface, channel generators and noise LFSR
    always_comb begin
        wr_d     = wr_n;
        gg_d     = gg_wr_n;
        ready_d  = ready_q;
        wait_d   = wait_q;
        regn_d   = regn_q;
        ctrl3_d  = ctrl3_q;
        vol_d    = vol_q;
        tone_d   = tone_q;
        cnt_d    = cnt_q;
        tout_d   = tout_q;
        pan_d    = pan_q;
        div_d    = div_q;
        ndiv_d   = ndiv_q;
        nint_d   = nint_q;
        nsrc_d   = nclk_s;
        lfsr_d   = lfsr_q;
        reseed_s = 1'b0;
        nlast_s  = 6'd63;

        if (clk_en) begin
            div_d = cen_ch_s ? '0 : div_q + DW'(1);
        end else begin
            div_d = div_q;
        end

        if (wr_acc_s && (WAIT_CYC != 0)) begin
            ready_d = 1'b0;
            wait_d  = WAIT_LD;
        end else if (!ready_q && clk_en) begin
            if (wait_q <= 16'd1) begin
                ready_d = 1'b1;
                wait_d  = 16'd0;
            end else begin
                wait_d  = wait_q - 16'd1;
            end
        end else begin
            wait_d = wait_q;
        end

        if (wr_acc_s) begin
            if (din[7]) begin
                regn_d = din[6:4];
                if (din[4]) begin
                    vol_d[din[6:5]] = din[3:0];
                end else if (din[6:5] != 2'd3) begin
                    tone_d[din[6:5]][3:0] = din[3:0];
                end else begin
                    ctrl3_d  = din[2:0];
                    reseed_s = 1'b1;
                end
            end else begin
                if (regn_q[0]) begin
                    vol_d[regn_q[2:1]] = din[3:0];
                end else if (regn_q[2:1] != 2'd3) begin
                    tone_d[regn_q[2:1]][9:4] = din[5:0];
                end else begin
                    ctrl3_d = ctrl3_q;
                end
            end
        end else begin
            regn_d = regn_q;
        end

        if (gg_acc_s) begin
            pan_d = din;
        end else begin
            pan_d = pan_q;
        end

        // Tone period 0 or 1 parks the output high for sample playback.
        for (int i = 0; i < 3; i++) begin
            if (cen_ch_s) begin
                if (cnt_q[i] == 10'd0) begin
                    cnt_d[i]  = tone_q[i] - 10'd1;
                    tout_d[i] = (tone_q[i] <= 10'd1) ? 1'b1 : ~tout_q[i];
                end else begin
                    cnt_d[i]  = cnt_q[i] - 10'd1;
                    tout_d[i] = (tone_q[i] <= 10'd1) ? 1'b1 : tout_q[i];
                end
            end else begin
                cnt_d[i]  = cnt_q[i];
                tout_d[i] = tout_q[i];
            end
        end

        case (ctrl3_q[1:0])
            2'b00:   nlast_s = 6'd15;
            2'b01:   nlast_s = 6'd31;
            default: nlast_s = 6'd63;
        endcase

        if (cen_ch_s) begin
            if (ndiv_q >= nlast_s) begin
                ndiv_d = 6'd0;
                nint_d = ~nint_q;
            end else begin
                ndiv_d = ndiv_q + 6'd1;
            end
        end else begin
            ndiv_d = ndiv_q;
        end

        if (reseed_s || (lfsr_q == '0)) begin
            lfsr_d = SEED;
        end else if (nclk_s && !nsrc_q) begin
            lfsr_d = {fb_s, lfsr_q[NOISE_W-1:1]};
        end else begin
            lfsr_d = lfsr_q;
        end
    end

    // Per-side mix of the panned channel levels
    always_comb begin
        mix_l_s = 10'd0;
        mix_r_s = 10'd0;
        for (int i = 0; i < 4; i++) begin
            lvl_s[i] = on_s[i] ? att_lut(vol_q[i]) : 8'd0;
            if (pan_q[4+i]) begin
                mix_l_s = mix_l_s + {2'b00, lvl_s[i]};
            end else begin
                mix_l_s = mix_l_s;
            end
            if (pan_q[i]) begin
                mix_r_s = mix_r_s + {2'b00, lvl_s[i]};
            end else begin
                mix_r_s = mix_r_s;
            end
        end
        left_d  = clk_en ? mix_l_s : left_q;
        right_d = clk_en ? mix_r_s : right_q;
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q    <= 1'b1;
            gg_q    <= 1'b1;
            ready_q <= 1'b1;
            wait_q  <= 16'd0;
            regn_q  <= 3'd0;
            ctrl3_q <= 3'b100;
            vol_q   <= '{default: 4'hF};
            tone_q  <= '{default: 10'd0};
            cnt_q   <= '{default: 10'd0};
            tout_q  <= 3'd0;
            pan_q   <= 8'hFF;
            div_q   <= '0;
            ndiv_q  <= 6'd0;
            nint_q  <= 1'b0;
            nsrc_q  <= 1'b0;
            lfsr_q  <= SEED;
            left_q  <= 10'd0;
            right_q <= 10'd0;
        end else begin
            wr_q    <= wr_d;
            gg_q    <= gg_d;
            ready_q <= ready_d;
            wait_q  <= wait_d;
            regn_q  <= regn_d;
            ctrl3_q <= ctrl3_d;
            vol_q   <= vol_d;
            tone_q  <= tone_d;
            cnt_q   <= cnt_d;
            tout_q  <= tout_d;
            pan_q   <= pan_d;
            div_q   <= div_d;
            ndiv_q  <= ndiv_d;
            nint_q  <= nint_d;
            nsrc_q  <= nsrc_d;
            lfsr_q  <= lfsr_d;
            left_q  <= left_d;
            right_q <= right_d;
        end
    end

    assign ready = ready_q;
    assign left  = left_q;
    assign right = right_q;

endmodule

// File: tb/tb_jt89_stereo.sv
// Directed bench for jt89_stereo: a stereo instance and a STEREO=0 instance share all inputs.
module tb_jt89_stereo;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clk_en = 1'b1;
    logic       wr_n = 1'b1;
    logic       gg_wr_n = 1'b1;
    logic [7:0] din = 8'd0;
    logic       ready, ready_ns;
    logic [9:0] left, right, left_ns, right_ns;

    int errors = 0;
    int checks = 0;

    jt89_stereo dut (
        .clk(clk), .rst(rst), .clk_en(clk_en), .wr_n(wr_n), .gg_wr_n(gg_wr_n),
        .din(din), .ready(ready), .left(left), .right(right)
    );

    jt89_stereo #(.STEREO(1'b0)) dut_ns (
        .clk(clk), .rst(rst), .clk_en(clk_en), .wr_n(wr_n), .gg_wr_n(gg_wr_n),
        .din(din), .ready(ready_ns), .left(left_ns), .right(right_ns)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] sms_next(input logic [15:0] l);
        return {^(l & 16'h0009), l[15:1]};
    endfunction

    function automatic logic [15:0] per_next(input logic [15:0] l);
        return {l[0], l[15:1]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (ready !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        chk("wr_ready", 32'(ready), 32'd1);
    endtask

    task automatic psg_wr(input logic [7:0] d);
        wait_ready();
        din  = d;
        wr_n = 1'b0;
        tick();
        wr_n = 1'b1;
    endtask

    task automatic wait_lvl(input string tag, input bit side, input logic [9:0] v, input int lim);
        int n = 0;
        while (((side ? right : left) !== v) && n < lim) begin
            tick();
            n++;
        end
        chk(tag, 32'(side ? right : left), 32'(v));
    endtask

    task automatic run_len(output int n, input int lim);
        logic [9:0] s;
        s = left;
        n = 0;
        while (left === s && n < lim) begin
            tick();
            n++;
        end
    endtask

    initial begin
        int n;
        int bad;
        logic [15:0] base;

        // reset and idle
        repeat (3) tick();
        rst = 1'b0;
        tick();
        chk("rst_ready", 32'(ready), 32'd1);
        chk("rst_left", 32'(left), 32'd0);
        chk("rst_right", 32'(right), 32'd0);
        for (int i = 0; i < 4; i++) chk("rst_vol", 32'(dut.vol_q[i]), 32'hF);
        bad = 0;
        repeat (6) begin
            tick();
            if (left !== 10'd0 || right !== 10'd0 || ready !== 1'b1) bad = 1;
        end
        chk("idle", 32'(bad), 32'd0);

        // busy window: a write 5 ticks into it must be ignored
        psg_wr(8'h8F);
        chk("busy_drop", 32'(ready), 32'd0);
        n = 0;
        while (ready !== 1'b1 && n < 100) begin
            tick();
            n++;
            if (n == 5) begin
                din  = 8'hA5;
                wr_n = 1'b0;
            end
            if (n == 6) wr_n = 1'b1;
        end
        chk("wait_len", 32'(n), 32'd32);
        chk("drop_tone0", 32'(dut.tone_q[0]), 32'h00F);
        chk("drop_tone1", 32'(dut.tone_q[1]), 32'h000);
        chk("drop_regn", 32'(dut.regn_q), 32'd0);

        psg_wr(8'h01);
        psg_wr(8'h90);
        chk("tone0", 32'(dut.tone_q[0]), 32'h01F);
        chk("vol0", 32'(dut.vol_q[0]), 32'h0);

        // ch0 square wave: 31 cen_ch of 16 clocks per half period
        wait_lvl("ch0_on", 1'b0, 10'd255, 2000);
        run_len(n, 2000);
        chk("ch0_fall", 32'(left), 32'd0);
        run_len(n, 2000);
        chk("ch0_low", 32'(n), 32'd496);
        chk("ch0_hi_left", 32'(left), 32'd255);
        chk("ch0_hi_right", 32'(right), 32'd255);
        chk("ch0_ns_left", 32'(left_ns), 32'd255);
        run_len(n, 2000);
        chk("ch0_high", 32'(n), 32'd496);

        // clk_en low freezes the chip, including the wait counter
        psg_wr(8'h90);
        clk_en = 1'b0;
        repeat (600) tick();
        chk("frz_ready", 32'(ready), 32'd0);
        chk("frz_left", 32'(left), 32'd0);
        clk_en = 1'b1;

        // simultaneous PSG (vol1=0) and pan write, both with din=B0
        wait_ready();
        din     = 8'hB0;
        wr_n    = 1'b0;
        gg_wr_n = 1'b0;
        tick();
        wr_n    = 1'b1;
        gg_wr_n = 1'b1;
        chk("both_ready", 32'(ready), 32'd0);
        wait_lvl("mix_510", 1'b0, 10'd510, 1200);
        chk("pan_r0", 32'(right), 32'd0);
        chk("ns_r510", 32'(right_ns), 32'd510);
        wait_lvl("mix_255", 1'b0, 10'd255, 1200);
        chk("pan_r0b", 32'(right), 32'd0);

        psg_wr(8'hB2);
        wait_lvl("mix_416", 1'b0, 10'd416, 1200);

        wait_ready();
        din     = 8'h0F;
        gg_wr_n = 1'b0;
        tick();
        gg_wr_n = 1'b1;
        chk("pan_keeps_ready", 32'(ready), 32'd1);
        wait_lvl("pan_r416", 1'b1, 10'd416, 1200);
        chk("pan_l0", 32'(left), 32'd0);
        chk("ns_l416", 32'(left_ns), 32'd416);

        // white noise, internal /16 clock
        psg_wr(8'hE4);
        chk("seed", 32'(dut.lfsr_q), 32'h8000);
        for (int k = 0; k < 15; k++) begin
            base = dut.lfsr_q;
            n = 0;
            while (dut.lfsr_q === base && n < 600) begin
                tick();
                n++;
            end
            chk("sms_lfsr", 32'(dut.lfsr_q), 32'(sms_next(base)));
            if (k > 0) chk("sms_period", 32'(n), 32'd512);
        end

        // periodic noise clocked by tone2 = 0x010
        psg_wr(8'hC0);
        psg_wr(8'h01);
        psg_wr(8'hE3);
        chk("tone2", 32'(dut.tone_q[2]), 32'h010);
        tick();
        tick();
        for (int k = 0; k < 3; k++) begin
            base = dut.lfsr_q;
            n = 0;
            while (dut.lfsr_q === base && n < 20000) begin
                tick();
                n++;
            end
            chk("per_lfsr", 32'(dut.lfsr_q), 32'(per_next(base)));
            if (k > 0) chk("per_period", 32'(n), 32'd512);
        end

        // reset while busy
        psg_wr(8'h9F);
        chk("busy_pre_rst", 32'(ready), 32'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_busy_ready", 32'(ready), 32'd1);
        chk("rst_busy_left", 32'(left), 32'd0);
        chk("rst_busy_lfsr", 32'(dut.lfsr_q), 32'h8000);
        chk("rst_busy_vol0", 32'(dut.vol_q[0]), 32'hF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
